// File: rtl/io_uart_if.sv
// CPU I/O port pair plus the serial line, seen from the UART peripheral (slave)
// and from the CPU/line side (master).
interface io_uart_if;
    logic [15:0] IO64_OUT;
    logic [15:0] IO65_IN;
    logic        UART_RXD;
    logic        UART_TXD;

    modport master (output IO64_OUT, output UART_RXD, input IO65_IN, input UART_TXD);
    modport slave  (input IO64_OUT, input UART_RXD, output IO65_IN, output UART_TXD);
endinterface

// File: rtl/io_uart.sv
// UART bridging the CPU level ports (toggle handshakes) to an 8N1 serial line.
// Define IO_UART_PARITY_EN to add an even-parity bit to both directions.
module io_uart #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic     CLK,
    input  logic     RESET_N,
    io_uart_if.slave uart
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef IO_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic          rxd_s1_q, rxd_s1_d, rxd_s2_q, rxd_s2_d;
    state_t        tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic [7:0]    tx_data_q, tx_data_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic          tx_ack_q, tx_ack_d, tx_busy_q, tx_busy_d, txd_q, txd_d;
    logic          rx_tog_q, rx_tog_d, rx_ovr_q, rx_ovr_d, rx_fe_q, rx_fe_d;
    logic          tx_tick, rx_tick, rx_pending, rx_pe_w, unused_bits;
`ifdef IO_UART_PARITY_EN
    logic          rx_par_q, rx_par_d, rx_pe_q, rx_pe_d;
    assign rx_pe_w = rx_pe_q;
`else
    assign rx_pe_w = 1'b0;
`endif

    assign tx_tick     = (tx_cnt_q == BIT_END);
    assign rx_tick     = (rx_cnt_q == BIT_END);
    assign rx_pending  = (rx_tog_q != uart.IO64_OUT[14]);
    assign unused_bits = ^{uart.IO64_OUT[13], uart.IO64_OUT[11:8]};

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;
        tx_ack_d   = tx_ack_q;
        tx_busy_d  = tx_busy_q;
        txd_d      = txd_q;
        if (tx_state_q != S_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
        unique case (tx_state_q)
            S_IDLE: begin
                // Level comparison: a toggle made while busy is picked up here later.
                if (uart.IO64_OUT[15] != tx_ack_q) begin
                    tx_ack_d   = uart.IO64_OUT[15];
                    tx_data_d  = uart.IO64_OUT[7:0];
                    tx_busy_d  = 1'b1;
                    txd_d      = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = S_START;
                end
            end
            S_START: if (tx_tick) begin
                tx_idx_d   = 3'd0;
                txd_d      = tx_data_q[0];
                tx_state_d = S_DATA;
            end
            S_DATA: if (tx_tick) begin
                if (tx_idx_q == 3'd7) begin
`ifdef IO_UART_PARITY_EN
                    txd_d      = ^tx_data_q;
                    tx_state_d = S_PARITY;
`else
                    txd_d      = 1'b1;
                    tx_state_d = S_STOP;
`endif
                end else begin
                    tx_idx_d = tx_idx_q + 3'd1;
                    txd_d    = tx_data_q[tx_idx_q + 3'd1];
                end
            end
`ifdef IO_UART_PARITY_EN
            S_PARITY: if (tx_tick) begin
                txd_d      = 1'b1;
                tx_state_d = S_STOP;
            end
`endif
            S_STOP: if (tx_tick) begin
                tx_busy_d  = 1'b0;
                tx_state_d = S_IDLE;
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rxd_s1_d   = uart.UART_RXD;
        rxd_s2_d   = rxd_s1_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_tog_d   = rx_tog_q;
        rx_ovr_d   = rx_ovr_q;
        rx_fe_d    = rx_fe_q;
`ifdef IO_UART_PARITY_EN
        rx_par_d   = rx_par_q;
        rx_pe_d    = rx_pe_q;
`endif
        if (rx_state_q != S_IDLE) rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
        unique case (rx_state_q)
            S_IDLE: if (!rxd_s2_q) begin
                rx_cnt_d   = '0;
                rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == HALF_END) begin
                // From here on every full bit time lands on a bit centre.
                rx_cnt_d   = '0;
                rx_idx_d   = 3'd0;
                rx_state_d = rxd_s2_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_tick) begin
                rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
                rx_idx_d   = rx_idx_q + 3'd1;
                if (rx_idx_q == 3'd7) begin
`ifdef IO_UART_PARITY_EN
                    rx_state_d = S_PARITY;
`else
                    rx_state_d = S_STOP;
`endif
                end
            end
`ifdef IO_UART_PARITY_EN
            S_PARITY: if (rx_tick) begin
                rx_par_d   = rxd_s2_q;
                rx_state_d = S_STOP;
            end
`endif
            S_STOP: if (rx_tick) begin
                rx_state_d = S_IDLE;
                if (!rxd_s2_q) begin
                    rx_fe_d = 1'b1;
`ifdef IO_UART_PARITY_EN
                end else if ((^rx_shift_q) != rx_par_q) begin
                    rx_pe_d = 1'b1;
`endif
                end else if (rx_pending) begin
                    rx_ovr_d = 1'b1;
                end else begin
                    rx_data_d = rx_shift_q;
                    rx_tog_d  = ~rx_tog_q;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
        if (uart.IO64_OUT[12]) begin
            rx_ovr_d = 1'b0;
            rx_fe_d  = 1'b0;
`ifdef IO_UART_PARITY_EN
            rx_pe_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            tx_data_q  <= 8'h00;
            tx_ack_q   <= 1'b0;
            tx_busy_q  <= 1'b0;
            txd_q      <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_tog_q   <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_fe_q    <= 1'b0;
`ifdef IO_UART_PARITY_EN
            rx_par_q   <= 1'b0;
            rx_pe_q    <= 1'b0;
`endif
        end else begin
            rxd_s1_q   <= rxd_s1_d;
            rxd_s2_q   <= rxd_s2_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_data_q  <= tx_data_d;
            tx_ack_q   <= tx_ack_d;
            tx_busy_q  <= tx_busy_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_tog_q   <= rx_tog_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_fe_q    <= rx_fe_d;
`ifdef IO_UART_PARITY_EN
            rx_par_q   <= rx_par_d;
            rx_pe_q    <= rx_pe_d;
`endif
        end
    end

    assign uart.IO65_IN  = {rx_tog_q, tx_busy_q, tx_ack_q, rx_ovr_q, rx_fe_q, rx_pe_w,
                            2'b00, rx_data_q};
    assign uart.UART_TXD = txd_q;
endmodule

// File: tb/tb_io_uart.sv
// Bench for io_uart: frame-level reference model of both directions compared
// against the DUT every cycle, plus literal spot checks on key states.
module tb_io_uart;
    localparam int CPB = 16;
`ifdef IO_UART_PARITY_EN
    localparam int NB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 10;
    localparam bit PAR = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET_N;
    always #5 CLK = ~CLK;

    io_uart_if ifc();
    logic       tx_req, rx_ack, err_clr, rxd_drv;
    logic [7:0] tx_byte;
    assign ifc.IO64_OUT = {tx_req, rx_ack, 1'b0, err_clr, 4'h0, tx_byte};
    assign ifc.UART_RXD = rxd_drv;

    io_uart #(.CLKS_PER_BIT(CPB)) dut (.CLK(CLK), .RESET_N(RESET_N), .uart(ifc));

    // Model state (written only by the model process)
    int          cyc;
    bit          m_busy, m_ack, m_rx_tog, m_ovr, m_fe, m_pe;
    int          m_pos;
    bit [NB-1:0] m_frame;
    bit [7:0]    m_rx_data;

    // Expected RX completion event (written only by the RX stimulus)
    int       ev_cyc;
    bit [7:0] ev_byte;
    bit       ev_stop, ev_par_ok;

    // Literal spot checks (written only by main)
    int          pin_id;
    string       pin_name;
    logic [16:0] pin_mask, pin_val;

    int checks, errors;

    function automatic bit [NB-1:0] make_frame(input bit [7:0] b, input bit stop, input bit bad_par);
        bit [NB-1:0] f;
        f      = '0;
        f[8:1] = b;
        if (PAR) f[9] = (^b) ^ bad_par;
        f[NB-1] = stop;
        return f;
    endfunction

    // Reference model: a TX frame is a bit vector indexed by elapsed time; an
    // RX byte resolves at a fixed cycle after its start bit hits the line.
    initial begin
        cyc = 0;
        forever begin
            @(posedge CLK or negedge RESET_N);
            if (!RESET_N) begin
                m_busy = 0; m_ack = 0; m_pos = 0; m_frame = '1;
                m_rx_tog = 0; m_rx_data = 0; m_ovr = 0; m_fe = 0; m_pe = 0;
            end else begin
                cyc++;
                if (cyc == ev_cyc) begin
                    if (!ev_stop)                 m_fe = 1;
                    else if (!ev_par_ok)          m_pe = 1;
                    else if (m_rx_tog != rx_ack)  m_ovr = 1;
                    else begin
                        m_rx_data = ev_byte;
                        m_rx_tog  = ~m_rx_tog;
                    end
                end
                if (err_clr) begin m_ovr = 0; m_fe = 0; m_pe = 0; end
                if (m_busy) begin
                    m_pos++;
                    if (m_pos == NB * CPB) m_busy = 0;
                end else if (tx_req != m_ack) begin
                    m_ack   = tx_req;
                    m_busy  = 1;
                    m_pos   = 0;
                    m_frame = make_frame(tx_byte, 1'b1, 1'b0);
                end
            end
        end
    end

    // Single compare process
    initial begin
        logic        exp_txd;
        logic [15:0] exp_io;
        int          last_pin;
        checks = 0; errors = 0; last_pin = 0;
        forever begin
            @(negedge CLK);
            exp_txd = m_busy ? m_frame[m_pos / CPB] : 1'b1;
            exp_io  = {m_rx_tog, m_busy, m_ack, m_ovr, m_fe, m_pe, 2'b00, m_rx_data};
            checks++;
            if (ifc.UART_TXD !== exp_txd) begin
                errors++;
                $display("FAIL txd t=%0t got=%b exp=%b", $time, ifc.UART_TXD, exp_txd);
            end
            checks++;
            if (ifc.IO65_IN !== exp_io) begin
                errors++;
                $display("FAIL io65 t=%0t got=%h exp=%h", $time, ifc.IO65_IN, exp_io);
            end
            if (pin_id != last_pin) begin
                last_pin = pin_id;
                checks++;
                if (({ifc.UART_TXD, ifc.IO65_IN} & pin_mask) !== pin_val) begin
                    errors++;
                    $display("FAIL %s got=%h exp=%h mask=%h", pin_name,
                             {ifc.UART_TXD, ifc.IO65_IN} & pin_mask, pin_val, pin_mask);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic pin(input string name, input logic [16:0] mask, input logic [16:0] val);
        pin_name = name;
        pin_mask = mask;
        pin_val  = val;
        pin_id++;
        step(1);
    endtask

    task automatic send_frame(input bit [7:0] b, input bit stop, input bit bad_par);
        bit [NB-1:0] f;
        f         = make_frame(b, stop, bad_par);
        ev_byte   = b;
        ev_stop   = stop;
        ev_par_ok = !bad_par;
        // 2 sync flops + detect edge, half bit to centre, then NB-1 full bits
        ev_cyc    = cyc + 3 + CPB / 2 + (NB - 1) * CPB;
        for (int k = 0; k < NB; k++) begin
            rxd_drv = f[k];
            step(CPB);
        end
        rxd_drv = 1'b1;
        $display("rx frame byte=%h stop=%b bad_par=%b", b, stop, bad_par);
    endtask

    task automatic tx_random();
        for (int i = 0; i < 25; i++) begin
            step($urandom_range(1, 250));
            tx_byte = 8'($urandom);
            tx_req  = ~tx_req;
            $display("tx request byte=%h toggle=%b", tx_byte, tx_req);
        end
        step(2 * NB * CPB + 10);
    endtask

    task automatic rx_random();
        bit [7:0] b;
        bit       stop, bad;
        for (int i = 0; i < 20; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            bad  = PAR && ($urandom_range(0, 4) == 0);
            send_frame(b, stop, bad);
            step($urandom_range(CPB, 3 * CPB));
            if ($urandom_range(0, 2) != 0) rx_ack = m_rx_tog;
            if ($urandom_range(0, 3) == 0) begin
                err_clr = 1'b1;
                step($urandom_range(1, 3));
                err_clr = 1'b0;
            end
            step(2);
        end
    endtask

    initial begin
        tx_req = 0; rx_ack = 0; err_clr = 0; tx_byte = 0; rxd_drv = 1;
        ev_cyc = -1; pin_id = 0; pin_name = ""; pin_mask = '0; pin_val = '0;
        RESET_N = 1'b1;
        #1 RESET_N = 1'b0;
        step(3);
        RESET_N = 1'b1;
        step(5);
        pin("reset_idle", 17'h1FFFF, 17'h10000);

        // Asynchronous reset in the middle of a TX frame
        tx_byte = 8'h41; tx_req = 1'b1;
        step(40);
        RESET_N = 1'b0; tx_req = 1'b0; tx_byte = 8'h00;
        pin("async_reset", 17'h1FFFF, 17'h10000);
        step(3);
        RESET_N = 1'b1;
        step(30);
        pin("no_frame_after_reset", 17'h16000, 17'h10000);

        // TX 16'h8041, then 16'h0055 queued while busy
        tx_byte = 8'h41; tx_req = 1'b1;
        $display("tx request byte=41 toggle=1");
        step(1);
        pin("tx_start", 17'h16000, 17'h06000);
        step(60);
        tx_byte = 8'h55; tx_req = 1'b0;
        $display("tx request byte=55 toggle=0 (while busy)");
        step(100);
        pin("tx_back_to_back", 17'h16000, 17'h04000);
        step(170);
        pin("tx_done", 17'h16000, 17'h10000);

        // RX A5, then a short glitch
        send_frame(8'hA5, 1'b1, 1'b0);
        step(CPB);
        pin("rx_a5", 17'h080FF, 17'h080A5);
        rx_ack = 1'b1;
        step(5);
        rxd_drv = 1'b0; step(2); rxd_drv = 1'b1;
        step(3 * CPB);
        pin("glitch_ignored", 17'h080FF, 17'h080A5);

        // Overrun, clear, ack, fresh byte
        send_frame(8'h11, 1'b1, 1'b0);
        step(CPB);
        send_frame(8'h22, 1'b1, 1'b0);
        step(CPB);
        pin("overrun", 17'h090FF, 17'h01011);
        err_clr = 1'b1;
        step(2);
        pin("err_clear", 17'h01C00, 17'h00000);
        err_clr = 1'b0; rx_ack = 1'b0;
        step(2);
        send_frame(8'h33, 1'b1, 1'b0);
        step(CPB);
        pin("rx_33", 17'h090FF, 17'h08033);

        // Frame error keeps data and toggle
        send_frame(8'h3C, 1'b0, 1'b0);
        step(CPB);
        pin("frame_err", 17'h088FF, 17'h08833);
`ifdef IO_UART_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1);
        step(CPB);
        pin("parity_err", 17'h084FF, 17'h08433);
`endif
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0; rx_ack = 1'b1;
        step(2);

        fork
            tx_random();
            rx_random();
        join
        step(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
